// File: rtl/board_ctrl_pkg.sv
// rtl/board_ctrl_pkg.sv - run-state encoding and sizing helpers for the board run controller
package board_ctrl_pkg;

    localparam int RUN_STATE_W = 2;

    localparam logic [RUN_STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [RUN_STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [RUN_STATE_W-1:0] ST_STEP = 2'd2;
    localparam logic [RUN_STATE_W-1:0] ST_HALT = 2'd3;

    typedef enum logic [RUN_STATE_W-1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_STEP = ST_STEP,
        S_HALT = ST_HALT
    } run_state_e;

    // Counter only has to reach cycles-1 before the level flips.
    function automatic int debounce_cnt_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/board_run_ctrl_if.sv
// rtl/board_run_ctrl_if.sv - raw input / debounced level / press pulse bundle
interface board_run_ctrl_if #(
    parameter int W = 1
);
    logic [W-1:0] raw;
    logic [W-1:0] level;
    logic [W-1:0] press;

    modport master (output raw, input level, input press);
    modport slave  (input raw, output level, output press);
endinterface

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - 2-FF synchroniser, stability counter, debounced level and rising-edge pulse
module debounce_cell
    import board_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic            clk,
    input  logic            resetn,
    board_run_ctrl_if.slave db
);

    localparam int CW = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          prev_q, press_q;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= db.raw[0];
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
            press_q <= level_q & ~prev_q;
        end
    end

    assign db.level = level_q;
    assign db.press = press_q;

endmodule

// File: rtl/board_run_ctrl.sv
// rtl/board_run_ctrl.sv - board input debouncing, status LEDs and run/step/halt phase sequencer
module board_run_ctrl
    import board_ctrl_pkg::*;
#(
    parameter int NUM_BTN         = 2,
    parameter int NUM_SW          = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PHASES          = 4,
    parameter int MEM_PHASE       = 1,
    parameter int RUN_BTN         = 0,
    parameter int STEP_SW         = 0
) (
    input  logic                      CLK,
    input  logic                      RESET_n,
    input  logic [NUM_BTN-1:0]        btn_raw,
    input  logic [NUM_SW-1:0]         sw_raw,
    input  logic                      endProgram,
    output logic [NUM_BTN-1:0]        btn_level,
    output logic [NUM_BTN-1:0]        btn_press,
    output logic [NUM_SW-1:0]         sw_level,
    output logic                      CPUEn,
    output logic                      MemEn,
    output logic [RUN_STATE_W-1:0]    run_state,
    output logic [NUM_SW+NUM_BTN:0]   leds
);

    localparam int PH_W = (PHASES > 2) ? $clog2(PHASES) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);
    localparam logic [PH_W-1:0] PH_MEM  = PH_W'(MEM_PHASE);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        board_run_ctrl_if #(.W(1)) db_if ();
        assign db_if.raw = btn_raw[i];
        debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
            .clk    (CLK),
            .resetn (RESET_n),
            .db     (db_if)
        );
        assign btn_level[i] = db_if.level[0];
        assign btn_press[i] = db_if.press[0];
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        board_run_ctrl_if #(.W(1)) db_if ();
        assign db_if.raw = sw_raw[i];
        debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
            .clk    (CLK),
            .resetn (RESET_n),
            .db     (db_if)
        );
        assign sw_level[i] = db_if.level[0];
    end

    run_state_e    state_q;
    logic [PH_W-1:0] phase_q;
    logic          pause_q;
    logic          run_press, step_mode, phase_last, active;

    assign run_press  = btn_press[RUN_BTN];
    assign step_mode  = sw_level[STEP_SW];
    assign phase_last = (phase_q == PH_LAST);

    // endProgram is checked first in every branch so it outranks press, pause and step end.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            pause_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (endProgram) begin
                        state_q <= S_HALT;
                    end else if (run_press) begin
                        state_q <= step_mode ? S_STEP : S_RUN;
                        phase_q <= '0;
                    end
                end
                S_RUN: begin
                    if (endProgram) begin
                        state_q <= S_HALT;
                        phase_q <= '0;
                    end else begin
                        phase_q <= phase_last ? '0 : phase_q + 1'b1;
                        if (phase_last && pause_q) begin
                            state_q <= S_IDLE;
                            pause_q <= 1'b0;
                        end else if (run_press) begin
                            pause_q <= 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    if (endProgram) begin
                        state_q <= S_HALT;
                        phase_q <= '0;
                    end else if (phase_last) begin
                        state_q <= S_IDLE;
                        phase_q <= '0;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign active    = (state_q == S_RUN) || (state_q == S_STEP);
    assign CPUEn     = active && phase_last;
    assign MemEn     = active && (phase_q == PH_MEM);
    assign run_state = state_q;
    assign leds      = {state_q == S_HALT, btn_level, sw_level};

endmodule

// File: tb/tb_board_run_ctrl.sv
// tb/tb_board_run_ctrl.sv - self-checking bench for board_run_ctrl (narrow and wide configurations)
module tb_board_run_ctrl;

    localparam int D = 4;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RESET_n;
    int   n_cmp = 0;
    int   n_err = 0;

    board_run_ctrl_if #(.W(2)) btn_if ();
    logic [3:0]  sw_raw0, sw_level0;
    logic        end0, cpu0, mem0;
    logic [1:0]  st0;
    logic [6:0]  leds0;

    logic [1:0]  btn_raw1, bl1, bp1;
    logic [7:0]  sw_raw1, sl1;
    logic        end1, cpu1, mem1;
    logic [1:0]  st1;
    logic [10:0] leds1;

    board_run_ctrl #(.NUM_BTN(2), .NUM_SW(4), .DEBOUNCE_CYCLES(D), .PHASES(4), .MEM_PHASE(1),
                     .RUN_BTN(0), .STEP_SW(0)) u_dut0 (
        .CLK(CLK), .RESET_n(RESET_n), .btn_raw(btn_if.raw), .sw_raw(sw_raw0), .endProgram(end0),
        .btn_level(btn_if.level), .btn_press(btn_if.press), .sw_level(sw_level0),
        .CPUEn(cpu0), .MemEn(mem0), .run_state(st0), .leds(leds0));

    board_run_ctrl #(.NUM_BTN(2), .NUM_SW(8), .DEBOUNCE_CYCLES(D), .PHASES(6), .MEM_PHASE(3),
                     .RUN_BTN(0), .STEP_SW(0)) u_dut1 (
        .CLK(CLK), .RESET_n(RESET_n), .btn_raw(btn_raw1), .sw_raw(sw_raw1), .endProgram(end1),
        .btn_level(bl1), .btn_press(bp1), .sw_level(sl1),
        .CPUEn(cpu1), .MemEn(mem1), .run_state(st1), .leds(leds1));

    // Reference model: inputs are seen two cycles late, a level follows after D
    // consecutive disagreeing samples, CPU cycles are counted from mode entry.
    int nsw_k[2] = '{4, 8};
    int ph_k[2]  = '{4, 6};
    int mp_k[2]  = '{1, 3};
    bit m_d1[2][10], m_d2[2][10], m_lvl[2][10], m_rose[2][10], m_prs[2][10];
    int m_run[2][10];
    int m_st[2], m_cyc[2];
    bit m_pause[2];

    task automatic model_step(input int k, input bit rst, input bit endp,
                              input logic [1:0] btn, input logic [7:0] sw);
        bit prs, stepm, pz, samp, raw;
        if (!rst) begin
            for (int j = 0; j < 10; j++) begin
                m_d1[k][j] = 0; m_d2[k][j] = 0; m_lvl[k][j] = 0;
                m_rose[k][j] = 0; m_prs[k][j] = 0; m_run[k][j] = 0;
            end
            m_st[k] = 0; m_cyc[k] = 0; m_pause[k] = 0;
            return;
        end
        prs = m_prs[k][0]; stepm = m_lvl[k][2]; pz = m_pause[k];
        case (m_st[k])
            0: if (endp) m_st[k] = 3;
               else if (prs) begin m_st[k] = stepm ? 2 : 1; m_cyc[k] = 0; m_pause[k] = 0; end
            1: if (endp) m_st[k] = 3;
               else begin
                   if (prs) m_pause[k] = 1;
                   if ((m_cyc[k] % ph_k[k]) == ph_k[k] - 1 && pz) begin m_st[k] = 0; m_pause[k] = 0; end
                   else m_cyc[k]++;
               end
            2: if (endp) m_st[k] = 3;
               else if (m_cyc[k] == ph_k[k] - 1) m_st[k] = 0;
               else m_cyc[k]++;
            default: ;
        endcase
        for (int j = 0; j < 2 + nsw_k[k]; j++) begin
            raw  = (j < 2) ? btn[j] : sw[j-2];
            samp = m_d2[k][j];
            m_d2[k][j] = m_d1[k][j];
            m_d1[k][j] = raw;
            m_prs[k][j] = m_rose[k][j];
            m_rose[k][j] = 0;
            if (samp != m_lvl[k][j]) begin
                m_run[k][j]++;
                if (m_run[k][j] == D) begin m_lvl[k][j] = samp; m_run[k][j] = 0; m_rose[k][j] = samp; end
            end else m_run[k][j] = 0;
        end
    endtask

    function automatic logic [26:0] exp_vec(input int k);
        logic [1:0] bl, bp, s;
        logic [7:0] sl;
        logic act, cpu, mem, halted;
        int ph;
        sl = '0;
        for (int j = 0; j < 2; j++) begin bl[j] = m_lvl[k][j]; bp[j] = m_prs[k][j]; end
        for (int j = 0; j < nsw_k[k]; j++) sl[j] = m_lvl[k][2+j];
        s = 2'(m_st[k]);
        ph = m_cyc[k] % ph_k[k];
        act = (m_st[k] == 1) || (m_st[k] == 2);
        cpu = act && (ph == ph_k[k] - 1);
        mem = act && (ph == mp_k[k]);
        halted = (m_st[k] == 3);
        if (k == 0) return {8'b0, bl, bp, sl[3:0], s, cpu, mem, halted, bl, sl[3:0]};
        return {bl, bp, sl, s, cpu, mem, halted, bl, sl};
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_step(0, RESET_n, end0, btn_if.raw, {4'b0, sw_raw0});
        model_step(1, RESET_n, end1, btn_raw1, sw_raw1);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        int np0, np1;
        RESET_n = 0; btn_if.raw = '1; sw_raw0 = '1; btn_raw1 = '1; sw_raw1 = '1; end0 = 0; end1 = 0;
        repeat (3) tick();
        n_cmp++; if ({btn_if.level, btn_if.press, sw_level0} !== '0) begin n_err++;
            $display("FAIL reset_levels: got %h required 0", {btn_if.level, btn_if.press, sw_level0}); end
        n_cmp++; if ({cpu0, mem0} !== 2'b00) begin n_err++; $display("FAIL reset_enables: got %b required 00", {cpu0, mem0}); end
        n_cmp++; if (st0 !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d required 0", st0); end
        n_cmp++; if (leds0 !== '0 || leds1 !== '0) begin n_err++; $display("FAIL reset_leds: got %h/%h required 0", leds0, leds1); end
        RESET_n = 1;
        repeat (5) tick();
        n_cmp++; if (btn_if.level !== 2'b00) begin n_err++; $display("FAIL level_early: got %b required 00", btn_if.level); end
        tick();
        n_cmp++; if (btn_if.level !== 2'b11) begin n_err++; $display("FAIL level_latency: got %b required 11", btn_if.level); end
        np0 = 0; np1 = 0;
        repeat (6) begin tick(); np0 += int'(btn_if.press[0]); np1 += int'(btn_if.press[1]); end
        n_cmp++; if (np0 != 1 || np1 != 1) begin n_err++; $display("FAIL reset_press_count: got %0d/%0d required 1/1", np0, np1); end
    endtask

    task automatic test_glitch();
        bit seen;
        int np;
        btn_if.raw = '0; btn_raw1 = '0;
        repeat (8) tick();
        seen = 0;
        btn_if.raw[0] = 1;
        repeat (3) begin tick(); seen |= btn_if.level[0] | btn_if.press[0]; end
        btn_if.raw[0] = 0;
        repeat (12) begin tick(); seen |= btn_if.level[0] | btn_if.press[0]; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL glitch_reject: level/press seen=%b required 0", seen); end
        np = 0;
        btn_if.raw[0] = 1;
        repeat (4) begin tick(); np += int'(btn_if.press[0]); end
        btn_if.raw[0] = 0;
        repeat (14) begin tick(); np += int'(btn_if.press[0]); end
        n_cmp++; if (np != 1) begin n_err++; $display("FAIL glitch_accept: presses=%0d required 1", np); end
    endtask

    task automatic test_run();
        int n, lc, lm, nc;
        bit bad, prev_cpu;
        sw_raw0[0] = 0;
        repeat (8) tick();
        n_cmp++; if (st0 !== 2'd0) begin n_err++; $display("FAIL run_pre_idle: state=%0d required 0", st0); end
        btn_if.raw[0] = 1;
        n = 0; while (st0 !== 2'd1 && n < 20) begin tick(); n++; end
        n_cmp++; if (st0 !== 2'd1) begin n_err++; $display("FAIL run_enter: state=%0d required 1", st0); end
        lc = -1; lm = -100; nc = 0; bad = 0;
        for (int t = 0; t < 16; t++) begin
            if (mem0) lm = t;
            if (cpu0) begin nc++; if ((lc >= 0 && t - lc != 4) || t - lm != 2) bad = 1; lc = t; end
            tick();
        end
        n_cmp++; if (nc != 4) begin n_err++; $display("FAIL run_cpuen_count: got %0d required 4", nc); end
        n_cmp++; if (bad) begin n_err++; $display("FAIL run_spacing: CPUEn period/MemEn offset wrong, got bad=1 required 0"); end
        btn_if.raw[0] = 0;
        repeat (8 + $urandom_range(3)) tick();
        btn_if.raw[0] = 1;
        n = 0; while (btn_if.press[0] !== 1'b1 && n < 12) begin tick(); n++; end
        n_cmp++; if (btn_if.press[0] !== 1'b1) begin n_err++; $display("FAIL pause_press: press=%b required 1", btn_if.press[0]); end
        nc = 0; prev_cpu = 0; n = 0;
        while (n < 12) begin
            tick(); n++;
            if (st0 === 2'd0) break;
            nc += int'(cpu0); prev_cpu = cpu0;
        end
        n_cmp++; if (st0 !== 2'd0 || nc != 1 || !prev_cpu) begin n_err++;
            $display("FAIL pause_drain: state=%0d cpuen=%0d last=%b required 0/1/1", st0, nc, prev_cpu); end
        btn_if.raw[0] = 0;
        repeat (8) tick();
    endtask

    task automatic test_step();
        int nm, nc;
        bit saw_step;
        sw_raw0[0] = 1;
        repeat (8) tick();
        btn_if.raw[0] = 1;
        nm = 0; nc = 0; saw_step = 0;
        repeat (30) begin tick(); nm += int'(mem0); nc += int'(cpu0); saw_step |= (st0 === 2'd2); end
        n_cmp++; if (nm != 1 || nc != 1 || !saw_step) begin n_err++;
            $display("FAIL step_one_cycle: mem=%0d cpu=%0d step=%b required 1/1/1", nm, nc, saw_step); end
        n_cmp++; if (st0 !== 2'd0) begin n_err++; $display("FAIL step_idle: state=%0d required 0", st0); end
        btn_if.raw[0] = 0;
        repeat (8) tick();
    endtask

    task automatic test_halt();
        int n;
        bit bad;
        sw_raw0[0] = 0;
        repeat (8) tick();
        btn_if.raw[0] = 1;
        n = 0; while (st0 !== 2'd1 && n < 20) begin tick(); n++; end
        btn_if.raw[0] = 0;
        repeat (8) tick();
        n = 0; while (cpu0 !== 1'b1 && n < 8) begin tick(); n++; end
        n_cmp++; if (cpu0 !== 1'b1 || st0 !== 2'd1) begin n_err++; $display("FAIL halt_sync: cpuen=%b state=%0d required 1/1", cpu0, st0); end
        btn_if.raw[0] = 1;
        repeat (7) tick();
        n_cmp++; if ({btn_if.press[0], cpu0, mem0} !== 3'b100) begin n_err++;
            $display("FAIL halt_phase2_press: press/cpu/mem=%b required 100", {btn_if.press[0], cpu0, mem0}); end
        end0 = 1;
        tick();
        end0 = 0;
        n_cmp++; if (st0 !== 2'd3 || leds0[6] !== 1'b1) begin n_err++;
            $display("FAIL halt_enter: state=%0d led=%b required 3/1", st0, leds0[6]); end
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (c % 7 == 0) btn_if.raw[0] = ~btn_if.raw[0];
            tick();
            if (cpu0 !== 1'b0 || mem0 !== 1'b0 || st0 !== 2'd3) bad = 1;
        end
        n_cmp++; if (bad) begin n_err++; $display("FAIL halt_sticky: enables or state moved, got bad=1 required 0"); end
        RESET_n = 0;
        tick();
        RESET_n = 1;
        n_cmp++; if ({st0, cpu0, mem0, leds0} !== '0) begin n_err++;
            $display("FAIL halt_reset: got %h required 0", {st0, cpu0, mem0, leds0}); end
        btn_if.raw = '0;
        repeat (8) tick();
    endtask

    task automatic test_wide();
        int n, lc, lm, nc;
        bit bad;
        sw_raw1 = 8'hA4; btn_raw1 = '0;
        repeat (8) tick();
        n_cmp++; if (leds1 !== {1'b0, 2'b00, 8'hA4} || st1 !== 2'd0) begin n_err++;
            $display("FAIL wide_leds: leds=%h state=%0d required %h/0", leds1, st1, {1'b0, 2'b00, 8'hA4}); end
        btn_raw1[0] = 1;
        n = 0; while (st1 !== 2'd1 && n < 20) begin tick(); n++; end
        n_cmp++; if (st1 !== 2'd1) begin n_err++; $display("FAIL wide_enter: state=%0d required 1", st1); end
        lc = -1; lm = -100; nc = 0; bad = 0;
        for (int t = 0; t < 24; t++) begin
            if (mem1) lm = t;
            if (cpu1) begin nc++; if ((lc >= 0 && t - lc != 6) || t - lm != 2) bad = 1; lc = t; end
            tick();
        end
        n_cmp++; if (nc != 4 || bad) begin n_err++; $display("FAIL wide_spacing: cpuen=%0d bad=%b required 4/0", nc, bad); end
        n_cmp++; if (leds1[10:8] !== 3'b001) begin n_err++; $display("FAIL wide_led_btn: got %b required 001", leds1[10:8]); end
        end1 = 1;
        tick();
        end1 = 0;
        n_cmp++; if (st1 !== 2'd3) begin n_err++; $display("FAIL wide_halt: state=%0d required 3", st1); end
    endtask

    task automatic test_random();
        RESET_n = 0;
        tick();
        RESET_n = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int j = 0; j < 2; j++) begin
                if ($urandom_range(5) == 0) btn_if.raw[j] = ~btn_if.raw[j];
                if ($urandom_range(5) == 0) btn_raw1[j] = ~btn_raw1[j];
            end
            for (int j = 0; j < 4; j++) if ($urandom_range(5) == 0) sw_raw0[j] = ~sw_raw0[j];
            for (int j = 0; j < 8; j++) if ($urandom_range(5) == 0) sw_raw1[j] = ~sw_raw1[j];
            end0 = ($urandom_range(799) == 0);
            end1 = ($urandom_range(799) == 0);
            RESET_n = ($urandom_range(249) != 0);
            tick();
            n_cmp++;
            if ({8'b0, btn_if.level, btn_if.press, sw_level0, st0, cpu0, mem0, leds0} !== exp_vec(0)) begin
                n_err++;
                $display("FAIL random_inst0 cycle %0d: got %h required %h", c,
                         {8'b0, btn_if.level, btn_if.press, sw_level0, st0, cpu0, mem0, leds0}, exp_vec(0));
            end
            n_cmp++;
            if ({bl1, bp1, sl1, st1, cpu1, mem1, leds1} !== exp_vec(1)) begin
                n_err++;
                $display("FAIL random_inst1 cycle %0d: got %h required %h", c,
                         {bl1, bp1, sl1, st1, cpu1, mem1, leds1}, exp_vec(1));
            end
        end
        RESET_n = 1; end0 = 0; end1 = 0;
    endtask

    initial begin
        RESET_n = 0; btn_if.raw = '0; sw_raw0 = '0; end0 = 0;
        btn_raw1 = '0; sw_raw1 = '0; end1 = 0;
        @(negedge CLK);
        test_reset();
        test_glitch();
        test_run();
        test_step();
        test_halt();
        test_wide();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
